stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Parametrised valid/ready stream buffer with registered storage of Depth entries, DataWidth bits each.
- Adds an occupancy count, almost-full/almost-empty flags, synchronous flush, and support for Depth values that are not a power of two (pointer wrap at Depth).
- Placed between any two valid/ready stream stages to absorb rate mismatch and backpressure.

Parameters:
- DataWidth, 8, payload width in bits (>=1).
- Depth, 5, number of entries (>=2; any integer, not restricted to a power of two).
- AlmostFullThr, 4, almost_full_o asserts when count >= this value (1..Depth).
- AlmostEmptyThr, 1, almost_empty_o asserts when count <= this value (0..Depth-1).

Ports:
- clk_i  in  1  clock, rising edge.
- arst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush; discards all entries.
- data_in_i  in  DataWidth  input payload.
- data_in_valid_i  in  1  input payload valid.
- data_in_ready_o  out  1  FIFO can accept input.
- data_out_o  out  DataWidth  head-of-FIFO payload.
- data_out_valid_o  out  1  head entry valid.
- data_out_ready_i  in  1  downstream accepts head.
- count_o  out  $clog2(Depth+1)  current occupancy.
- almost_full_o  out  1  count_o >= AlmostFullThr.
- almost_empty_o  out  1  count_o <= AlmostEmptyThr.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-high, on arst_i. While arst_i is high: wr_ptr=0, rd_ptr=0, count=0.
- Outputs during and after reset (flush_i low): data_in_ready_o=1, data_out_valid_o=0, data_out_o=0, count_o=0, almost_full_o=0, almost_empty_o=1. Storage array is not reset.
- Push condition: push = data_in_valid_i & data_in_ready_o. Pop condition: pop = data_out_valid_o & data_out_ready_i.
- data_in_ready_o = (count < Depth) & ~flush_i. There is no bypass, so a full FIFO does not accept input even when a pop occurs in the same cycle.
- data_out_valid_o = (count != 0) & ~flush_i.
- data_out_o = mem[rd_ptr] when count != 0; otherwise 0.
- Latency: data pushed at edge N is visible on data_out_o with data_out_valid_o=1 after edge N. Minimum latency is 1 cycle; there is no combinational fall-through.
- Push: mem[wr_ptr] <= data_in_i; wr_ptr advances 0..Depth-1 and wraps to 0 after Depth-1.
- Pop: rd_ptr advances with the same wrap rule.
- Count update:
  - push & ~pop: count +1.
  - pop & ~push: count -1.
  - push & pop: count unchanged; both pointers advance.
- Backpressure: while data_out_valid_o=1 and data_out_ready_i=0, data_out_o holds stable until popped.
- Flush: when flush_i=1 at an edge, wr_ptr, rd_ptr and count all go to 0. Flush takes priority over push and pop, and the ready/valid gating above ensures neither handshake completes in that cycle.
- Flags: almost_full_o and almost_empty_o are combinational compares on count and update in the same cycle as count_o.
- Reset mid-operation: all stored entries are discarded immediately (asynchronous). Outputs take their reset values without waiting for a clock edge.
- Protocol assumptions: an upstream producer holds data_in_i stable while valid is high and ready is low. The block does not check this.

Test Plan:
- Reset and fill: assert arst_i, release, then push 0x11,0x22,0x33,0x44,0x55 with data_out_ready_i=0 -> count_o 1..5; data_in_ready_o=0 after the 5th push; almost_full_o=1 from count 4; 6th offered value 0x66 is not accepted.
- Drain order: from the full state, hold data_out_ready_i=1 -> data_out_o sequence 0x11,0x22,0x33,0x44,0x55 on consecutive cycles; data_out_valid_o=0 and almost_empty_o=1 afterwards.
- Simultaneous push/pop and wrap-around: at count=3, push and pop every cycle for 12 cycles with incrementing data -> count_o stays 3; output equals input delayed by 3 transactions; pointers wrap past index 4 with no data loss.
- Backpressure hold: with count=2, toggle data_out_ready_i 0,0,1 -> data_out_o stays on the head value for 2 cycles, then advances.
- Flush with traffic: at count=4, assert flush_i for 1 cycle with push and pop both requested -> during that cycle data_in_ready_o=0 and data_out_valid_o=0; next cycle count_o=0 and the next pushed value 0xA5 appears as head after 1 cycle.
- Async reset mid-stream: at count=3, pulse arst_i between clock edges -> count_o=0, data_out_valid_o=0, data_out_o=0, data_in_ready_o=1 immediately, before the next edge.

Source files
------------

// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle for stream_fifo: an upstream push side, a downstream pop side and occupancy status.
// The slave modport is the FIFO's view; master is the surrounding logic or bench.
interface stream_fifo_if #(
  parameter int DataWidth = 8,
  parameter int Depth     = 5
);
  localparam int CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] data_in_i;
  logic                 data_in_valid_i;
  logic                 data_in_ready_o;
  logic [DataWidth-1:0] data_out_o;
  logic                 data_out_valid_o;
  logic                 data_out_ready_i;
  logic [CntW-1:0]      count_o;
  logic                 almost_full_o;
  logic                 almost_empty_o;

  modport slave (
    input  data_in_i, data_in_valid_i, data_out_ready_i,
    output data_in_ready_o, data_out_o, data_out_valid_o,
           count_o, almost_full_o, almost_empty_o
  );

  modport master (
    output data_in_i, data_in_valid_i, data_out_ready_i,
    input  data_in_ready_o, data_out_o, data_out_valid_o,
           count_o, almost_full_o, almost_empty_o
  );
endinterface

// File: rtl/stream_fifo.sv
// Registered valid/ready FIFO of Depth entries (any Depth >= 2) with occupancy count,
// almost-full/almost-empty flags and a synchronous flush that overrides push and pop.
module stream_fifo #(
  parameter int DataWidth      = 8,
  parameter int Depth          = 5,
  parameter int AlmostFullThr  = 4,
  parameter int AlmostEmptyThr = 1
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          flush_i,
  stream_fifo_if.slave  bus
);
  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = $clog2(Depth);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count;
  logic                 push;
  logic                 pop;
  logic                 not_empty;

  // Pointers wrap explicitly at Depth so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return '0;
    end
    return ptr + PtrW'(1);
  endfunction

  assign not_empty            = (count != '0);
  assign bus.data_in_ready_o  = (count < CntW'(Depth)) & ~flush_i;
  assign bus.data_out_valid_o = not_empty & ~flush_i;
  assign bus.data_out_o       = not_empty ? mem[rd_ptr] : '0;
  assign bus.count_o          = count;
  assign bus.almost_full_o    = (count >= CntW'(AlmostFullThr));
  assign bus.almost_empty_o   = (count <= CntW'(AlmostEmptyThr));

  assign push = bus.data_in_valid_i & bus.data_in_ready_o;
  assign pop  = bus.data_out_valid_o & bus.data_out_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in_i;
    end
  end

  // The ready/valid gating already blocks both handshakes during flush; flush is still given priority here.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CntW'(1);
      end else if (pop && !push) begin
        count <= count - CntW'(1);
      end
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a queue scoreboard tracks accepted payloads and predicts every output each cycle.
module tb_stream_fifo;
  localparam int DataWidth = 8;
  localparam int Depth     = 5;

  logic clk_i   = 1'b0;
  logic arst_i  = 1'b1;
  logic flush_i = 1'b0;

  logic [DataWidth-1:0] sb_q[$];
  int vectors     = 0;
  int miscompares = 0;

  stream_fifo_if #(.DataWidth(DataWidth), .Depth(Depth)) bus ();

  stream_fifo #(
    .DataWidth(DataWidth), .Depth(Depth), .AlmostFullThr(4), .AlmostEmptyThr(1)
  ) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .flush_i(flush_i),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compares every output against the scoreboard for the current inputs.
  task automatic checkAll(input string step);
    int sz;
    logic [31:0] exp_data;
    sz = sb_q.size();
    exp_data = (sz != 0) ? 32'(sb_q[0]) : 32'h0;
    checkOutput({step, ".count"},  32'(bus.count_o),          32'(sz));
    checkOutput({step, ".ready"},  32'(bus.data_in_ready_o),  32'((sz < Depth) && !flush_i));
    checkOutput({step, ".valid"},  32'(bus.data_out_valid_o), 32'((sz != 0) && !flush_i));
    checkOutput({step, ".data"},   32'(bus.data_out_o),       exp_data);
    checkOutput({step, ".afull"},  32'(bus.almost_full_o),    32'(sz >= 4));
    checkOutput({step, ".aempty"}, 32'(bus.almost_empty_o),   32'(sz <= 1));
  endtask

  // Drives one cycle of inputs, checks outputs, updates the scoreboard, then advances past the edge.
  task automatic applyStimulus(input string step, input logic v, input logic [DataWidth-1:0] d,
                               input logic ordy, input logic fl);
    bit push_ok;
    bit pop_ok;
    bus.data_in_valid_i  = v;
    bus.data_in_i        = d;
    bus.data_out_ready_i = ordy;
    flush_i              = fl;
    #2;
    checkAll(step);
    push_ok = v && (sb_q.size() < Depth) && !fl;
    pop_ok  = ordy && (sb_q.size() != 0) && !fl;
    if (fl) begin
      sb_q.delete();
    end
    if (pop_ok) begin
      void'(sb_q.pop_front());
    end
    if (push_ok) begin
      sb_q.push_back(d);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bus.data_in_i        = '0;
    bus.data_in_valid_i  = 1'b0;
    bus.data_out_ready_i = 1'b0;
    #2;
    checkAll("reset");
    #1;
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkAll("post_reset");

    // Fill to full; the sixth offer (0x66) must be refused.
    applyStimulus("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus("fill2", 1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus("fill3", 1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus("fill4", 1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus("fill5", 1'b1, 8'h66, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Bring occupancy to 3, then stream through with the pointers wrapping.
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("pre%0d", i), 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("thru%0d", i), 1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
    end

    // Down to 2 entries, then backpressure 0,0,1.
    applyStimulus("pop_to2", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("bp0", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("bp1", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("bp2", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("bp3", 1'b0, 8'h00, 1'b0, 1'b0);

    // From 1 entry up to 4, then flush with both handshakes requested.
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("up%0d", i), 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    end
    applyStimulus("flush", 1'b1, 8'hEE, 1'b1, 1'b1);
    applyStimulus("after_flush", 1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus("head_a5", 1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus("to3", 1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("count3_before_reset", 32'(bus.count_o), 32'd3);

    // Asynchronous reset pulse between edges; outputs must react before any clock edge.
    bus.data_in_valid_i  = 1'b0;
    bus.data_out_ready_i = 1'b0;
    #1;
    arst_i = 1'b1;
    sb_q.delete();
    #1;
    checkAll("async_reset");
    #1;
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;
    applyStimulus("post_async", 1'b1, 8'h3C, 1'b1, 1'b0);
    applyStimulus("final", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
